// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, fetches from imem, queues {pc, instr} for decode.
// Define IFU_PERF_CNT_EN to build the fetch/redirect performance counters.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        misalign_o,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    fq_entry_t       fq [FIFO_DEPTH];
    logic [31:0]     pc;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     count;
    logic            pop;
    logic            fetch;
    fq_entry_t       head;

    assign imem_addr = pc;
    assign id_valid  = (count != '0);
    assign pop       = id_valid & id_ready;
    assign fetch     = !redirect_i & !stall_i & ((count != DEPTH) | pop);
    assign head      = fq[rptr];

    assign id_pc       = id_valid ? head.pc : 32'h0;
    assign id_instr    = id_valid ? head.instr : 32'h0;
    assign id_pc_plus4 = id_valid ? head.pc + 32'd4 : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= redirect_i & (|redirect_pc_i[1:0]);
            if (redirect_i) begin
                // Flush wins over any push/pop in the same cycle.
                pc    <= {redirect_pc_i[31:2], 2'b00};
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (fetch) begin
                    pc   <= pc + 32'd4;
                    wptr <= wptr + 1'b1;
                end
                if (pop)
                    rptr <= rptr + 1'b1;
                unique case (1'b1)
                    fetch & !pop: count <= count + 1'b1;
                    pop & !fetch: count <= count - 1'b1;
                    default:      count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                fq[i] <= '0;
        end else if (fetch) begin
            fq[wptr] <= '{pc: pc, instr: imem_rdata};
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redir_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (fetch)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect_i)
                redir_cnt <= redir_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt    = fetch_cnt;
    assign perf_redirect_cnt = redir_cnt;
`else
    assign perf_fetch_cnt    = 32'h0;
    assign perf_redirect_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; imem returns 0x1000_0000 + address.
// Expected values are hand-derived per step.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_o;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;

    int errs   = 0;
    int checks = 0;

    ifu_fetch #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .id_valid         (id_valid),
        .id_ready         (id_ready),
        .id_instr         (id_instr),
        .id_pc            (id_pc),
        .id_pc_plus4      (id_pc_plus4),
        .misalign_o       (misalign_o),
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
    );

    assign imem_rdata = 32'h1000_0000 + imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] p);
        chk({tag, "_v"}, 32'(id_valid), 32'd1);
        chk({tag, "_pc"}, id_pc, p);
        chk({tag, "_ins"}, id_instr, 32'h1000_0000 + p);
        chk({tag, "_p4"}, id_pc_plus4, p + 32'd4);
    endtask

    initial begin
        rst           = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        id_ready      = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_p4", id_pc_plus4, 32'h0);
        chk("rst_mis", 32'(misalign_o), 32'd0);
        chk("rst_pf", perf_fetch_cnt, 32'h0);
        chk("rst_pr", perf_redirect_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // streaming with decode always ready
        tick(); head("s0", 32'h0);
        chk("s0_addr", imem_addr, 32'h4);
        tick(); head("s1", 32'h4);
        tick(); head("s2", 32'h8);
        tick(); head("s3", 32'hC);

        // restart at 0, then hold decode off until queue fills
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0;
        id_ready      = 1'b0;
        tick();
        chk("r0_valid", 32'(id_valid), 32'd0);
        chk("r0_addr", imem_addr, 32'h0);
        redirect_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        head("full_h", 32'h0);
        chk("full_addr", imem_addr, 32'h8);
        id_ready = 1'b1;
        tick(); head("dr1", 32'h4);
        tick(); head("dr2", 32'h8);
        tick(); head("dr3", 32'hC);

        // redirect while full
        id_ready      = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        chk("rf_valid", 32'(id_valid), 32'd0);
        chk("rf_addr", imem_addr, 32'h40);
        chk("rf_mis", 32'(misalign_o), 32'd0);
        redirect_i = 1'b0;
        id_ready   = 1'b1;
        tick(); head("rf_h", 32'h40);

        // redirect overrides stall
        redirect_i    = 1'b1;
        stall_i       = 1'b1;
        redirect_pc_i = 32'h80;
        tick();
        chk("rs_valid", 32'(id_valid), 32'd0);
        chk("rs_addr", imem_addr, 32'h80);
        redirect_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_valid", 32'(id_valid), 32'd0);
            chk("st_addr", imem_addr, 32'h80);
        end
        stall_i = 1'b0;
        tick(); head("st_h", 32'h80);

        // misaligned target
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h43;
        tick();
        chk("ma_addr", imem_addr, 32'h40);
        chk("ma_mis", 32'(misalign_o), 32'd1);
        chk("ma_valid", 32'(id_valid), 32'd0);
        redirect_i = 1'b0;
        tick();
        chk("ma_mis2", 32'(misalign_o), 32'd0);
        head("ma_h", 32'h40);
`ifdef IFU_PERF_CNT_EN
        chk("pf_redir", perf_redirect_cnt, 32'd4);
        chk("pf_fetch", perf_fetch_cnt, 32'd12);
`else
        chk("pf_redir", perf_redirect_cnt, 32'd0);
        chk("pf_fetch", perf_fetch_cnt, 32'd0);
`endif

        // PC wrap at top of address space
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        tick();
        chk("wr_pc", id_pc, 32'hFFFF_FFFC);
        chk("wr_p4", id_pc_plus4, 32'h0);
        chk("wr_addr", imem_addr, 32'h0);
        tick(); head("wr_h", 32'h0);

        // asynchronous reset between edges
        #3;
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(id_valid), 32'd0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_pc", id_pc, 32'h0);
        chk("ar_pr", perf_redirect_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(); head("ar_h0", 32'h0);
        tick(); head("ar_h1", 32'h4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
